// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID/EX hazard inputs, pipeline enable/flush/bubble
// controls and the statistics counters, with master (pipeline) and slave (controller) views.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        ex_memread;
  logic [4:0]  ex_rt;
  logic        ex_branch_taken;
  logic        ex_jump;
  logic        ex_md_start;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_en;
  logic        idex_bubble;
  logic        md_busy;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rt,
           ex_branch_taken, ex_jump, ex_md_start,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, md_busy,
           stall_cycles, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memread, ex_rt,
           ex_branch_taken, ex_jump, ex_md_start,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, md_busy,
           stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, EX redirect flush, mult/div freeze.
// Optional HAZ_STATS_EN builds saturating stall/flush statistics counters.
module pipe_hazard_ctrl #(
  parameter int MD_LATENCY = 8,
  parameter int CNT_W      = $clog2(MD_LATENCY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

  // The start cycle is itself frozen, so MD_WAIT covers the remaining MD_LATENCY-2 cycles.
  localparam int              MD_WAIT_CYCLES = (MD_LATENCY > 2) ? (MD_LATENCY - 2) : 0;
  localparam bit              MD_STALLS      = (MD_LATENCY > 1);
  localparam bit              MD_HAS_WAIT    = (MD_LATENCY > 2);
  localparam logic [CNT_W-1:0] MD_LOAD       = CNT_W'(MD_WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ZERO      = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  state_t           stateR;
  state_t           stateN;
  logic [CNT_W-1:0] mdCntR;
  logic [CNT_W-1:0] mdCntN;
  logic             loadUseS;
  logic             redirectS;
  logic             pcEnS;
  logic             ifidEnS;
  logic             ifidFlushS;
  logic             idexEnS;
  logic             idexBubbleS;
  logic             mdBusyS;

  // Hazard detection; register 0 is hard-wired and never produces a dependency.
  always_comb begin
    redirectS = bus.ex_branch_taken | bus.ex_jump;
    loadUseS  = bus.ex_memread & (bus.ex_rt != 5'd0) &
                ((bus.id_uses_rs & (bus.id_rs == bus.ex_rt)) |
                 (bus.id_uses_rt & (bus.id_rt == bus.ex_rt)));
  end

  // FSM state and mult/div down-counter registers.
  always_ff @(posedge clk) begin
    stateR <= stateN;
    mdCntR <= mdCntN;
  end

  // Next-state and control outputs; priority redirect > mult/div start > load-use.
  always_comb begin
    stateN      = stateR;
    mdCntN      = mdCntR;
    pcEnS       = 1'b0;
    ifidEnS     = 1'b0;
    ifidFlushS  = 1'b0;
    idexEnS     = 1'b0;
    idexBubbleS = 1'b0;
    mdBusyS     = 1'b0;
    if (reset) begin
      stateN = RUN;
      mdCntN = CNT_ZERO;
    end else begin
      case (stateR)
        RUN: begin
          pcEnS   = 1'b1;
          ifidEnS = 1'b1;
          idexEnS = 1'b1;
          if (redirectS) begin
            ifidFlushS  = 1'b1;
            idexBubbleS = 1'b1;
          end else if (bus.ex_md_start && MD_STALLS) begin
            pcEnS   = 1'b0;
            ifidEnS = 1'b0;
            idexEnS = 1'b0;
            mdBusyS = 1'b1;
            if (MD_HAS_WAIT) begin
              stateN = MD_WAIT;
              mdCntN = MD_LOAD;
            end else begin
              stateN = RUN;
              mdCntN = CNT_ZERO;
            end
          end else if (loadUseS) begin
            pcEnS       = 1'b0;
            ifidEnS     = 1'b0;
            idexBubbleS = 1'b1;
          end else begin
            idexBubbleS = 1'b0;
          end
        end
        MD_WAIT: begin
          mdBusyS = 1'b1;
          if (mdCntR <= CNT_ONE) begin
            stateN = RUN;
            mdCntN = CNT_ZERO;
          end else begin
            mdCntN = mdCntR - CNT_ONE;
          end
        end
        default: begin
          stateN = RUN;
          mdCntN = CNT_ZERO;
        end
      endcase
    end
  end

  assign bus.pc_en       = pcEnS;
  assign bus.ifid_en     = ifidEnS;
  assign bus.ifid_flush  = ifidFlushS;
  assign bus.idex_en     = idexEnS;
  assign bus.idex_bubble = idexBubbleS;
  assign bus.md_busy     = mdBusyS;

`ifdef HAZ_STATS_EN
  logic [31:0] stallCyclesR;
  logic [31:0] flushCountR;

  // Saturating statistics counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCyclesR <= 32'd0;
      flushCountR  <= 32'd0;
    end else begin
      if (!pcEnS && (stallCyclesR != 32'hFFFF_FFFF)) begin
        stallCyclesR <= stallCyclesR + 32'd1;
      end
      if (ifidFlushS && (flushCountR != 32'hFFFF_FFFF)) begin
        flushCountR <= flushCountR + 32'd1;
      end
    end
  end

  assign bus.stall_cycles = stallCyclesR;
  assign bus.flush_count  = flushCountR;
`else
  assign bus.stall_cycles = 32'd0;
  assign bus.flush_count  = 32'd0;
`endif

endmodule
